mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares one unified memory bus between the IF-stage instruction fetch port and the MEM-stage data port of the 5-stage pipeline.
- Serialises requests with one outstanding transaction at a time.
- Data accesses have priority; a starvation counter bounds how long a fetch can wait.
- Suppresses the response of a fetch cancelled by a taken-branch flush.

Parameters:
- MAX_WAIT, 4: consecutive data grants allowed while a fetch is pending, before the fetch is forced through (1..15).
- ADDR_W, 32: bus address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset (rst=0 resets).
- if_req  in  1  fetch request; held by IF until if_done.
- if_addr  in  ADDR_W  fetch address.
- if_flush  in  1  taken-branch flush; cancels any granted or pending fetch.
- if_done  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  32  fetched instruction.
- dm_cmd  in  2  0=BUS_NONE, 1=BUS_LOAD, 2=BUS_STORE; held until dm_done.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  32  store data.
- dm_done  out  1  one-cycle pulse; load data valid / store complete.
- dm_rdata  out  32  load data.
- mem_cmd  out  2  bus command (same encoding), registered.
- mem_addr  out  ADDR_W  bus address, registered.
- mem_wdata  out  32  bus store data, registered.
- mem_rdata  in  32  bus read data, valid with mem_done.
- mem_done  in  1  one-cycle completion pulse from memory.
- if_stall  out  1  equals if_req & ~if_done.
- dm_stall  out  1  equals (dm_cmd!=0) & ~dm_done.
- owner  out  2  0=idle, 1=fetch, 2=data, 3=flushed fetch draining (debug).

Behaviour:
- Reset (rst=0, async): state IDLE.
  - mem_cmd=0, mem_addr=0, mem_wdata=0.
  - if_done=0, dm_done=0, owner=0.
  - wait counter=0, flushed flag=0.
  - if_rdata/dm_rdata are pass-throughs of mem_rdata.
  - An in-flight transaction is abandoned. mem_done seen in IDLE is ignored.
- States:
  - IDLE: arbitrate.
  - BUSY_I: fetch on bus.
  - BUSY_D: data access on bus.
  - DRAIN_I: fetch on bus whose result is discarded.
- Arbitration, evaluated only in IDLE, at cycle t:
  - fetch eligible = if_req & ~if_flush.
  - data eligible = dm_cmd!=0.
  - Both eligible and counter<MAX_WAIT: grant data, counter+1.
  - Both eligible and counter==MAX_WAIT: grant fetch, counter cleared.
  - Only data eligible: grant data; counter cleared if if_req=0, else counter+1 (saturates at MAX_WAIT).
  - Only fetch eligible: grant fetch, counter cleared.
  - Neither eligible: stay IDLE; counter cleared when if_req=0.
- Grant at t:
  - At t+1, mem_cmd/addr/wdata carry the winner's command, address and data (mem_wdata=0 for loads and fetches).
  - The bus fields are held constant until mem_done.
  - Fetch grants always issue BUS_LOAD.
- Completion (mem_done=1 in BUSY_I/BUSY_D), same cycle:
  - The owner's done pulses and rdata is passed through combinationally.
  - Next cycle: mem_cmd=0, state IDLE.
  - Turnaround is one idle bus cycle, so the minimum transaction is 1 (issue) + bus latency + 1 (idle).
- Flush handling:
  - if_flush in BUSY_I: go to DRAIN_I, owner=3. The bus transaction continues unchanged.
  - mem_done in DRAIN_I: if_done stays 0; go to IDLE.
  - if_flush in the same cycle as mem_done in BUSY_I: if_done suppressed.
  - if_flush in BUSY_D or DRAIN_I: no effect.
  - if_flush in IDLE: the fetch loses eligibility that cycle only.
- Stores complete on mem_done; dm_rdata is don't-care for stores.
- Only one transaction is outstanding at a time; a mem_done in IDLE is a memory protocol error and is dropped.
- A requester changing cmd/addr while granted is illegal. The arbiter continues to drive its latched values.

Test Plan:
- Fetch only, if_addr=0x100, memory latency 2:
  - mem_cmd=1, mem_addr=0x100 at t+1.
  - mem_done at t+3 with rdata 0x00000013 gives if_done=1, if_rdata=0x13.
  - mem_cmd=0 at t+4.
- Simultaneous if_req and dm_cmd=LOAD at 0x2000:
  - Data is granted first; dm_done returns mem_rdata.
  - The fetch is granted in the next IDLE cycle.
- Starvation, MAX_WAIT=4, data requests back-to-back with if_req held: exactly 4 data grants, then a fetch grant, then counter=0.
- if_flush one cycle after a fetch grant: owner=3; mem_done arrives; if_done stays 0; next arbitration occurs normally.
- Store dm_cmd=2, addr=0x3000, wdata=0xDEADBEEF:
  - mem_cmd=2, mem_wdata=0xDEADBEEF held through 3 wait cycles.
  - dm_done pulses once.
- rst=0 asserted mid-BUSY_D: all outputs reset immediately. A later stray mem_done produces no done pulse; state remains IDLE.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_bus_arbiter_if: IF/MEM requester ports plus unified memory bus.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_done;
  logic [31:0]       if_rdata;

  logic [1:0]        dm_cmd;
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_wdata;
  logic              dm_done;
  logic [31:0]       dm_rdata;

  logic [1:0]        mem_cmd;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_done;

  logic              if_stall;
  logic              dm_stall;
  logic [1:0]        owner;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, if_flush, dm_cmd, dm_addr, dm_wdata, mem_rdata, mem_done,
    output if_done, if_rdata, dm_done, dm_rdata, mem_cmd, mem_addr, mem_wdata,
           if_stall, dm_stall, owner
  );

  // Pipeline-stage and memory side
  modport master (
    output if_req, if_addr, if_flush, dm_cmd, dm_addr, dm_wdata, mem_rdata, mem_done,
    input  if_done, if_rdata, dm_done, dm_rdata, mem_cmd, mem_addr, mem_wdata,
           if_stall, dm_stall, owner
  );
endinterface
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_bus_arbiter: single-outstanding fetch/data arbiter, data-priority with   |
// | starvation bound and flushed-fetch draining.   Revision: 1.0                 |
// +----------------------------------------------------------------------------+
module mem_bus_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int ADDR_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  mem_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_I  = 2'd1,
    BUSY_D  = 2'd2,
    DRAIN_I = 2'd3
  } state_e;

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;
  localparam logic [3:0] WAIT_MAX  = 4'(MAX_WAIT);

  state_e            state_q, state_d;
  logic [3:0]        wait_q, wait_d;
  logic [1:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              if_done;
  logic              dm_done;
  logic              fetch_elig;
  logic              data_elig;
  logic              starved;

  assign fetch_elig = bus.if_req & ~bus.if_flush;
  assign data_elig  = (bus.dm_cmd != BUS_NONE);
  assign starved    = (wait_q >= WAIT_MAX);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      wait_q  <= '0;
      cmd_q   <= BUS_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if_done = 1'b0;
    dm_done = 1'b0;
    case (state_q)
      IDLE: begin
        // Data wins unless a pending fetch has already waited MAX_WAIT grants
        if (data_elig && !(fetch_elig && starved)) begin
          state_d = BUSY_D;
          cmd_d   = bus.dm_cmd;
          addr_d  = bus.dm_addr;
          wdata_d = (bus.dm_cmd == BUS_STORE) ? bus.dm_wdata : 32'd0;
          if (!bus.if_req) begin
            wait_d = '0;
          end else if (!starved) begin
            wait_d = wait_q + 4'd1;
          end
        end else if (fetch_elig) begin
          state_d = BUSY_I;
          cmd_d   = BUS_LOAD;
          addr_d  = bus.if_addr;
          wdata_d = 32'd0;
          wait_d  = '0;
        end else if (!bus.if_req) begin
          wait_d = '0;
        end
      end
      BUSY_I: begin
        if (bus.mem_done) begin
          if_done = ~bus.if_flush;
          state_d = IDLE;
          cmd_d   = BUS_NONE;
        end else if (bus.if_flush) begin
          state_d = DRAIN_I;
        end
      end
      BUSY_D: begin
        if (bus.mem_done) begin
          dm_done = 1'b1;
          state_d = IDLE;
          cmd_d   = BUS_NONE;
        end
      end
      DRAIN_I: begin
        if (bus.mem_done) begin
          state_d = IDLE;
          cmd_d   = BUS_NONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.if_done   = if_done;
  assign bus.dm_done   = dm_done;
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.dm_rdata  = bus.mem_rdata;
  assign bus.mem_cmd   = cmd_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_stall  = bus.if_req & ~if_done;
  assign bus.dm_stall  = data_elig & ~dm_done;
  assign bus.owner     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_bus_arbiter: directed scenarios against a latency-programmable memory. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mem_bus_arbiter;
  localparam int ADDR_W   = 32;
  localparam int MAX_WAIT = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  mem_bus_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  mem_bus_arbiter #(.MAX_WAIT(MAX_WAIT), .ADDR_W(ADDR_W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Memory responder: latches each new command, answers mem_lat cycles later.
  bit         mem_auto  = 1'b1;
  bit         stray_req = 1'b0;
  int         mem_lat   = 2;
  bit         resp_busy = 1'b0;
  int         resp_rem  = 0;
  logic [1:0]  log_cmd[$];
  logic [31:0] log_addr[$];

  function automatic logic [31:0] rd_tab(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'h0000_0013;
      32'h0000_2000: return 32'hCAFE_F00D;
      32'h0000_0200: return 32'h0050_0093;
      default:       return {a[15:0], ~a[15:0]};
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        resp_busy     = 1'b0;
        bus.mem_done  = 1'b0;
        bus.mem_rdata = 32'h1234_5678;
      end else if (!mem_auto) begin
        bus.mem_done  = stray_req;
        bus.mem_rdata = 32'hBAD0_BAD0;
      end else begin
        bus.mem_done = 1'b0;
        if (resp_busy) begin
          resp_rem--;
          if (resp_rem == 0) begin
            bus.mem_done  = 1'b1;
            bus.mem_rdata = rd_tab(bus.mem_addr);
            resp_busy     = 1'b0;
          end
        end else if (bus.mem_cmd != 2'd0) begin
          resp_busy = 1'b1;
          resp_rem  = mem_lat;
          log_cmd.push_back(bus.mem_cmd);
          log_addr.push_back(bus.mem_addr);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (bus.mem_cmd !== 2'd0) $display("FAIL rst_mem_cmd: got %0h want 0", bus.mem_cmd); else n_pass++;
    n_checks++; if (bus.mem_addr !== 32'd0) $display("FAIL rst_mem_addr: got %0h want 0", bus.mem_addr); else n_pass++;
    n_checks++; if (bus.mem_wdata !== 32'd0) $display("FAIL rst_mem_wdata: got %0h want 0", bus.mem_wdata); else n_pass++;
    n_checks++; if (bus.if_done !== 1'b0) $display("FAIL rst_if_done: got %0b want 0", bus.if_done); else n_pass++;
    n_checks++; if (bus.dm_done !== 1'b0) $display("FAIL rst_dm_done: got %0b want 0", bus.dm_done); else n_pass++;
    n_checks++; if (bus.owner !== 2'd0) $display("FAIL rst_owner: got %0d want 0", bus.owner); else n_pass++;
    n_checks++; if (bus.if_rdata !== 32'h1234_5678) $display("FAIL rst_if_rdata: got %0h want 12345678", bus.if_rdata); else n_pass++;
    n_checks++; if (bus.dm_rdata !== 32'h1234_5678) $display("FAIL rst_dm_rdata: got %0h want 12345678", bus.dm_rdata); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fetch_only();
    mem_lat = 2;
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    @(negedge clk);
    n_checks++; if (bus.mem_cmd !== 2'd1) $display("FAIL fetch_cmd: got %0h want 1", bus.mem_cmd); else n_pass++;
    n_checks++; if (bus.mem_addr !== 32'h100) $display("FAIL fetch_addr: got %0h want 100", bus.mem_addr); else n_pass++;
    n_checks++; if (bus.mem_wdata !== 32'd0) $display("FAIL fetch_wdata: got %0h want 0", bus.mem_wdata); else n_pass++;
    n_checks++; if (bus.owner !== 2'd1) $display("FAIL fetch_owner: got %0d want 1", bus.owner); else n_pass++;
    n_checks++; if (bus.if_stall !== 1'b1) $display("FAIL fetch_stall: got %0b want 1", bus.if_stall); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.if_done !== 1'b0) $display("FAIL fetch_early_done: got %0b want 0", bus.if_done); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.if_done !== 1'b1) $display("FAIL fetch_done: got %0b want 1", bus.if_done); else n_pass++;
    n_checks++; if (bus.if_rdata !== 32'h13) $display("FAIL fetch_rdata: got %0h want 13", bus.if_rdata); else n_pass++;
    n_checks++; if (bus.if_stall !== 1'b0) $display("FAIL fetch_stall_rel: got %0b want 0", bus.if_stall); else n_pass++;
    bus.if_req = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.mem_cmd !== 2'd0) $display("FAIL fetch_turnaround: got %0h want 0", bus.mem_cmd); else n_pass++;
    n_checks++; if (bus.if_done !== 1'b0) $display("FAIL fetch_done_pulse: got %0b want 0", bus.if_done); else n_pass++;
    n_checks++; if (bus.owner !== 2'd0) $display("FAIL fetch_owner_idle: got %0d want 0", bus.owner); else n_pass++;
  endtask

  task automatic test_store();
    mem_lat = 4;
    bus.dm_cmd = 2'd2; bus.dm_addr = 32'h3000; bus.dm_wdata = 32'hDEAD_BEEF;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.mem_cmd, bus.mem_addr, bus.mem_wdata} !== {2'd2, 32'h3000, 32'hDEAD_BEEF})
        $display("FAIL store_hold_%0d: got %0h/%0h/%0h want 2/3000/deadbeef", i, bus.mem_cmd, bus.mem_addr, bus.mem_wdata);
      else n_pass++;
      n_checks++; if (bus.dm_done !== 1'b0) $display("FAIL store_early_done_%0d: got %0b want 0", i, bus.dm_done); else n_pass++;
    end
    @(negedge clk);
    n_checks++; if (bus.dm_done !== 1'b1) $display("FAIL store_done: got %0b want 1", bus.dm_done); else n_pass++;
    n_checks++; if (bus.mem_cmd !== 2'd2) $display("FAIL store_cmd_at_done: got %0h want 2", bus.mem_cmd); else n_pass++;
    n_checks++; if (bus.dm_stall !== 1'b0) $display("FAIL store_stall_rel: got %0b want 0", bus.dm_stall); else n_pass++;
    bus.dm_cmd = 2'd0;
    @(negedge clk);
    n_checks++; if (bus.dm_done !== 1'b0) $display("FAIL store_done_pulse: got %0b want 0", bus.dm_done); else n_pass++;
    n_checks++; if (bus.mem_cmd !== 2'd0) $display("FAIL store_turnaround: got %0h want 0", bus.mem_cmd); else n_pass++;
  endtask

  task automatic test_priority();
    mem_lat = 1;
    bus.if_req = 1'b1; bus.if_addr = 32'h200;
    bus.dm_cmd = 2'd1; bus.dm_addr = 32'h2000; bus.dm_wdata = 32'h5555_5555;
    @(negedge clk);
    n_checks++; if (bus.owner !== 2'd2) $display("FAIL prio_owner_data: got %0d want 2", bus.owner); else n_pass++;
    n_checks++; if (bus.mem_addr !== 32'h2000) $display("FAIL prio_addr_data: got %0h want 2000", bus.mem_addr); else n_pass++;
    n_checks++; if (bus.mem_wdata !== 32'd0) $display("FAIL prio_load_wdata: got %0h want 0", bus.mem_wdata); else n_pass++;
    n_checks++; if (bus.if_stall !== 1'b1) $display("FAIL prio_if_stall: got %0b want 1", bus.if_stall); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.dm_done !== 1'b1) $display("FAIL prio_dm_done: got %0b want 1", bus.dm_done); else n_pass++;
    n_checks++; if (bus.dm_rdata !== 32'hCAFE_F00D) $display("FAIL prio_dm_rdata: got %0h want cafef00d", bus.dm_rdata); else n_pass++;
    n_checks++; if (bus.if_done !== 1'b0) $display("FAIL prio_if_done_wrong: got %0b want 0", bus.if_done); else n_pass++;
    bus.dm_cmd = 2'd0;
    @(negedge clk);
    n_checks++; if (bus.mem_cmd !== 2'd0) $display("FAIL prio_turnaround: got %0h want 0", bus.mem_cmd); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.owner !== 2'd1) $display("FAIL prio_owner_fetch: got %0d want 1", bus.owner); else n_pass++;
    n_checks++; if (bus.mem_addr !== 32'h200) $display("FAIL prio_addr_fetch: got %0h want 200", bus.mem_addr); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.if_done !== 1'b1) $display("FAIL prio_if_done: got %0b want 1", bus.if_done); else n_pass++;
    n_checks++; if (bus.if_rdata !== 32'h0050_0093) $display("FAIL prio_if_rdata: got %0h want 00500093", bus.if_rdata); else n_pass++;
    bus.if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_starvation();
    logic [33:0] exp_q [10] = '{
      {2'd1, 32'h4000}, {2'd1, 32'h4004}, {2'd1, 32'h4008}, {2'd1, 32'h400C}, {2'd1, 32'h0300},
      {2'd1, 32'h4010}, {2'd1, 32'h4014}, {2'd1, 32'h4018}, {2'd1, 32'h401C}, {2'd1, 32'h0304}};
    int dn = 0;
    int fn = 0;
    mem_lat = 1;
    log_cmd.delete(); log_addr.delete();
    bus.if_req = 1'b1; bus.if_addr = 32'h300;
    bus.dm_cmd = 2'd1; bus.dm_addr = 32'h4000;
    for (int c = 0; c < 200 && fn < 2; c++) begin
      @(negedge clk);
      if (bus.dm_done === 1'b1) begin
        dn++;
        bus.dm_addr = 32'h4000 + 32'(dn * 4);
      end
      if (bus.if_done === 1'b1) begin
        fn++;
        if (fn == 1) bus.if_addr = 32'h304;
      end
    end
    bus.if_req = 1'b0; bus.dm_cmd = 2'd0;
    n_checks++; if (fn !== 2) $display("FAIL starve_timeout: got %0d fetches want 2", fn); else n_pass++;
    n_checks++; if (dn !== 8) $display("FAIL starve_data_count: got %0d want 8", dn); else n_pass++;
    n_checks++; if (log_addr.size() !== 10) $display("FAIL starve_grant_count: got %0d want 10", log_addr.size()); else n_pass++;
    for (int i = 0; i < 10 && i < log_addr.size(); i++) begin
      n_checks++;
      if ({log_cmd[i], log_addr[i]} !== exp_q[i])
        $display("FAIL starve_grant_%0d: got %0h want %0h", i, {log_cmd[i], log_addr[i]}, exp_q[i]);
      else n_pass++;
    end
    @(negedge clk);
  endtask

  task automatic test_flush();
    bit got = 1'b0;
    mem_lat = 3;
    bus.if_req = 1'b1; bus.if_addr = 32'h500;
    @(negedge clk);
    n_checks++; if (bus.owner !== 2'd1) $display("FAIL flush_granted: got %0d want 1", bus.owner); else n_pass++;
    bus.if_flush = 1'b1; bus.if_req = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.owner !== 2'd3) $display("FAIL flush_owner_drain: got %0d want 3", bus.owner); else n_pass++;
    n_checks++;
    if ({bus.mem_cmd, bus.mem_addr} !== {2'd1, 32'h500})
      $display("FAIL flush_bus_held: got %0h/%0h want 1/500", bus.mem_cmd, bus.mem_addr);
    else n_pass++;
    bus.if_flush = 1'b0; bus.if_req = 1'b1; bus.if_addr = 32'h600;
    @(negedge clk);
    n_checks++; if (bus.if_stall !== 1'b1) $display("FAIL flush_new_stall: got %0b want 1", bus.if_stall); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.if_done !== 1'b0) $display("FAIL flush_done_suppressed: got %0b want 0", bus.if_done); else n_pass++;
    n_checks++; if (bus.owner !== 2'd3) $display("FAIL flush_owner_at_done: got %0d want 3", bus.owner); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.owner !== 2'd0) $display("FAIL flush_idle: got %0d want 0", bus.owner); else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({bus.owner, bus.mem_addr} !== {2'd1, 32'h600})
      $display("FAIL flush_regrant: got %0d/%0h want 1/600", bus.owner, bus.mem_addr);
    else n_pass++;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (bus.if_done === 1'b1) begin
        got = 1'b1;
        n_checks++; if (bus.if_rdata !== 32'h0600_F9FF) $display("FAIL flush_new_rdata: got %0h want 0600f9ff", bus.if_rdata); else n_pass++;
      end
    end
    n_checks++; if (got !== 1'b1) $display("FAIL flush_new_timeout: got %0b want 1", got); else n_pass++;
    bus.if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_flush_on_done();
    mem_lat = 2;
    bus.if_req = 1'b1; bus.if_addr = 32'h700;
    @(negedge clk);
    n_checks++; if (bus.owner !== 2'd1) $display("FAIL fod_granted: got %0d want 1", bus.owner); else n_pass++;
    @(negedge clk);
    @(posedge clk);
    #2;
    bus.if_flush = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.if_done !== 1'b0) $display("FAIL fod_done_suppressed: got %0b want 0", bus.if_done); else n_pass++;
    bus.if_flush = 1'b0; bus.if_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.owner, bus.mem_cmd} !== {2'd0, 2'd0})
      $display("FAIL fod_idle: got %0d/%0h want 0/0", bus.owner, bus.mem_cmd);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    mem_lat = 5;
    bus.dm_cmd = 2'd1; bus.dm_addr = 32'h5000;
    @(negedge clk);
    n_checks++; if (bus.owner !== 2'd2) $display("FAIL rmid_granted: got %0d want 2", bus.owner); else n_pass++;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.owner !== 2'd0) $display("FAIL rmid_owner: got %0d want 0", bus.owner); else n_pass++;
    n_checks++; if (bus.mem_cmd !== 2'd0) $display("FAIL rmid_cmd: got %0h want 0", bus.mem_cmd); else n_pass++;
    n_checks++; if (bus.mem_addr !== 32'd0) $display("FAIL rmid_addr: got %0h want 0", bus.mem_addr); else n_pass++;
    bus.dm_cmd = 2'd0;
    @(negedge clk);
    rst_n = 1'b1; mem_auto = 1'b0; stray_req = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.dm_done !== 1'b0) $display("FAIL rmid_stray_dm: got %0b want 0", bus.dm_done); else n_pass++;
    n_checks++; if (bus.if_done !== 1'b0) $display("FAIL rmid_stray_if: got %0b want 0", bus.if_done); else n_pass++;
    stray_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.owner, bus.mem_cmd} !== {2'd0, 2'd0})
      $display("FAIL rmid_still_idle: got %0d/%0h want 0/0", bus.owner, bus.mem_cmd);
    else n_pass++;
    mem_auto = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    bus.if_req = 1'b0; bus.if_addr = '0; bus.if_flush = 1'b0;
    bus.dm_cmd = 2'd0; bus.dm_addr = '0; bus.dm_wdata = '0;
    test_reset();
    test_fetch_only();
    test_store();
    test_priority();
    test_starvation();
    test_flush();
    test_flush_on_done();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
